alu_muldiv_sequencer: RTL and testbench

- Multicycle unsigned multiply/divide sequencer that drives the team's N-bit ripple ALU as its datapath.
- It sits on the initiator side of the ALU interface: it generates a/b/carry-in/invert/less/operacion each cycle and consumes resultado and carry-out.
- Multiply is shift-add; divide is restoring. One ALU operation is issued per cycle, and one result bit is produced per cycle.

---
 rtl/alu_muldiv_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// Multicycle unsigned shift-add multiply / restoring divide that borrows an external
// ripple ALU as its only adder: one ALU op and one result bit per RUN cycle.
module alu_muldiv_sequencer #(
  parameter int          N      = 32,
  parameter logic [3:0]  OP_ADD = 4'b0010,
  parameter int          CW     = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o,
  output logic         div0_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic         alu_c_o,
  output logic         alu_invert_o,
  output logic         alu_less_o,
  output logic [3:0]   alu_operacion_o,
  input  logic [N-1:0] alu_resultado_i,
  input  logic         alu_c_i
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   h, l, m, dvs, hi_q, lo_q;
  logic           mode, div0, div0_q;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   s;
  logic           q;

  // Divide step: shifted partial remainder, and quotient bit (an overflowed H bit
  // means the shifted value already exceeds any N-bit divisor).
  assign s = {h[N-2:0], l[N-1]};
  assign q = h[N-1] | alu_c_i;

  always_comb begin
    state_nx     = state;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_c_o      = 1'b0;
    alu_invert_o = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = RUN;
      RUN: begin
        if (mode) begin
          alu_a_o      = s;
          alu_b_o      = dvs;
          alu_c_o      = 1'b1;
          alu_invert_o = 1'b1;
        end else begin
          alu_a_o = h;
          alu_b_o = m;
        end
        if (cnt == CW'(N-1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign alu_less_o      = 1'b0;
  assign alu_operacion_o = OP_ADD;
  assign busy_o          = (state == RUN);
  assign done_o          = (state == DONE);
  // Results are visible combinationally in DONE, then held from the shadow copies.
  assign hi_o            = done_o ? h    : hi_q;
  assign lo_o            = done_o ? l    : lo_q;
  assign div0_o          = done_o ? div0 : div0_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      h      <= '0;
      l      <= '0;
      m      <= '0;
      dvs    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      mode   <= 1'b0;
      div0   <= 1'b0;
      div0_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start_i) begin
          dvs    <= b_i;
          mode   <= op_i;
          h      <= '0;
          l      <= op_i ? a_i : b_i;
          if (!op_i) m <= a_i;
          cnt    <= '0;
          div0   <= op_i && (b_i == '0);
          div0_q <= 1'b0;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (mode) begin
            h <= q ? alu_resultado_i : s;
            l <= {l[N-2:0], q};
          end else if (l[0]) begin
            h <= {alu_c_i, alu_resultado_i[N-1:1]};
            l <= {alu_resultado_i[0], l[N-1:1]};
          end else begin
            h <= {1'b0, h[N-1:1]};
            l <= {h[0], l[N-1:1]};
          end
        end
        DONE: begin
          hi_q   <= h;
          lo_q   <= l;
          div0_q <= div0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer at N=8 with a behavioural ripple-ALU stand-in and
// a plain-arithmetic reference for product / quotient / remainder.
module tb_alu_muldiv_sequencer;
  localparam int         N      = 8;
  localparam logic [3:0] OP_ADD = 4'b0010;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [N-1:0] a, b;
  logic         busy, done, div0;
  logic [N-1:0] hi, lo;
  logic [N-1:0] alu_a, alu_b, alu_res;
  logic         alu_cin, alu_inv, alu_less, alu_cout;
  logic [3:0]   alu_op;
  logic [N:0]   sum;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] prev_hi = '0, prev_lo = '0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer #(.N(N), .OP_ADD(OP_ADD), .CW(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo), .div0_o(div0),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_o(alu_cin), .alu_invert_o(alu_inv),
    .alu_less_o(alu_less), .alu_operacion_o(alu_op),
    .alu_resultado_i(alu_res), .alu_c_i(alu_cout)
  );

  // ALU adder path: a + (invert ? ~b : b) + carry-in
  assign sum      = {1'b0, alu_a} + {1'b0, (alu_inv ? ~alu_b : alu_b)} + {{N{1'b0}}, alu_cin};
  assign alu_res  = sum[N-1:0];
  assign alu_cout = sum[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned product, or quotient/remainder with the all-ones divide-by-zero rule.
  task automatic model(input logic o, input logic [N-1:0] x, input logic [N-1:0] y,
                       output logic [N-1:0] ehi, output logic [N-1:0] elo, output logic ediv0);
    logic [2*N-1:0] p;
    if (!o) begin
      p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
      ehi = p[2*N-1:N]; elo = p[N-1:0]; ediv0 = 1'b0;
    end else if (y == '0) begin
      ehi = x; elo = '1; ediv0 = 1'b1;
    end else begin
      ehi = x % y; elo = x / y; ediv0 = 1'b0;
    end
  endtask

  // Issue one op in the current IDLE cycle and follow it to DONE.
  task automatic run_op(input string tag, input logic o, input logic [N-1:0] x,
                        input logic [N-1:0] y, input bit hold);
    logic [N-1:0] ehi, elo;
    logic         ediv0;
    model(o, x, y, ehi, elo, ediv0);
    @(negedge clk);
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_done"}, done, 0);
    chk({tag, ":idle_alu_a"}, alu_a, 0);
    start = 1'b1; op = o; a = x; b = y;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      if (!hold) begin start = 1'b0; a = $urandom; b = $urandom; op = $urandom; end
      chk({tag, ":run_busy"}, busy, 1);
      chk({tag, ":run_done"}, done, 0);
      chk({tag, ":run_hold_hi"}, hi, prev_hi);
      chk({tag, ":run_hold_lo"}, lo, prev_lo);
      chk({tag, ":run_div0"}, div0, 0);
      chk({tag, ":run_aluctl"}, {alu_less, alu_op, alu_cin, alu_inv}, {1'b0, OP_ADD, o, o});
    end
    @(negedge clk);
    chk({tag, ":done"}, done, 1);
    chk({tag, ":done_busy"}, busy, 0);
    chk({tag, ":hi"}, hi, ehi);
    chk({tag, ":lo"}, lo, elo);
    chk({tag, ":div0"}, div0, ediv0);
    prev_hi = ehi; prev_lo = elo;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_div0", div0, 0);
    chk("rst_alu", {alu_a, alu_b, alu_cin, alu_inv}, 0);
    rst = 1'b0;

    run_op("mul13x11", 1'b0, 8'd13, 8'd11, 1'b0);
    run_op("mulFFxFF", 1'b0, 8'hFF, 8'hFF, 1'b0);
    run_op("div100_7", 1'b1, 8'd100, 8'd7, 1'b0);
    run_op("divFF_80", 1'b1, 8'hFF, 8'h80, 1'b0);
    run_op("div5A_0", 1'b1, 8'h5A, 8'h00, 1'b0);
    // held start: one DONE only, then a start in the very next IDLE cycle
    run_op("hold_mul", 1'b0, 8'd7, 8'd9, 1'b1);
    run_op("b2b_mul3x5", 1'b0, 8'd3, 8'd5, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [N-1:0] x, y;
      x = N'($urandom);
      y = (k % 6 == 5) ? '0 : N'($urandom);
      run_op("rand", 1'($urandom), x, y, 1'b0);
    end

    // reset during cycle T+4 of a divide
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'd200; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_div0", div0, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 0);
    end
    prev_hi = '0; prev_lo = '0;
    run_op("after_abort", 1'b1, 8'd200, 8'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
